// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit accumulator core controller: opcodes, SYS sub-codes, FSM states.
package cpu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_LDA = 3'b010;
   localparam logic [2:0] OP_STA = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_JMP = 3'b110;
   localparam logic [2:0] OP_SYS = 3'b111;

   localparam logic [4:0] SYS_HLT = 5'd0;
   localparam logic [4:0] SYS_SKZ = 5'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_OPREAD,
      S_EXEC,
      S_STORE,
      S_HALT
   } state_t;

endpackage

// File: rtl/ctl_bus_timer.sv
// Memory wait counter: counts stalled cycles of the current transfer and flags a bus timeout.
module ctl_bus_timer #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic busy,
   input  logic ready,
   output logic expired
);

   logic [7:0] cnt;

   // Any cycle without an outstanding stalled transfer restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               cnt <= '0;
      else if (busy && !ready)  cnt <= cnt + 8'd1;
      else                      cnt <= '0;
   end

   assign expired = busy && !ready && (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator core over one shared memory port.
module alu_seq_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ready,
   output logic [2:0]        alu_opcode,
   output logic [7:0]        alu_a,
   output logic [7:0]        alu_b,
   input  logic [7:0]        alu_result,
   input  logic              alu_carry,
   output logic [7:0]        acc,
   output logic [ADDR_W-1:0] pc,
   output logic              z_flag,
   output logic              c_flag,
   output logic              halted,
   output logic              bus_err
);

   localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

   state_t            state, state_nxt;
   logic [7:0]        ir, mdr;
   logic [ADDR_W-1:0] pc_nxt;
   logic [2:0]        op;
   logic [4:0]        sub;
   logic [ADDR_W-1:0] tgt;
   logic              busy, timeout, restart;

   assign op      = ir[7:5];
   assign sub     = ir[4:0];
   assign tgt     = ir[ADDR_W-1:0];
   assign busy    = (state == S_FETCH) || (state == S_OPREAD) || (state == S_STORE);
   assign restart = start && ((state == S_IDLE) || (state == S_HALT));
   assign halted  = (state == S_HALT);
   assign alu_a   = acc;
   assign alu_b   = mdr;

   ctl_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .busy    (busy),
      .ready   (mem_ready),
      .expired (timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      case (state)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_nxt = S_FETCH;
               pc_nxt    = PC0;
            end
         end
         S_FETCH: begin
            if (mem_ready)    state_nxt = S_DECODE;
            else if (timeout) state_nxt = S_HALT;
         end
         S_DECODE: begin
            pc_nxt = pc + ADDR_W'(1);
            case (op)
               OP_STA: state_nxt = S_STORE;
               OP_JMP: begin
                  state_nxt = S_FETCH;
                  pc_nxt    = tgt;
               end
               OP_SYS: begin
                  state_nxt = (sub == SYS_HLT) ? S_HALT : S_FETCH;
                  if (sub == SYS_SKZ && z_flag) pc_nxt = pc + ADDR_W'(2);
               end
               default: state_nxt = S_OPREAD;
            endcase
         end
         S_OPREAD: begin
            if (mem_ready)    state_nxt = S_EXEC;
            else if (timeout) state_nxt = S_HALT;
         end
         S_EXEC: state_nxt = S_FETCH;
         S_STORE: begin
            if (mem_ready)    state_nxt = S_FETCH;
            else if (timeout) state_nxt = S_HALT;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bus outputs are registered from the next state so they are valid for the whole
   // cycle spent in the bus state and hold until the completing edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= PC0;
         acc        <= '0;
         ir         <= '0;
         mdr        <= '0;
         z_flag     <= 1'b0;
         c_flag     <= 1'b0;
         bus_err    <= 1'b0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         alu_opcode <= OP_ADD;
      end else begin
         pc     <= pc_nxt;
         mem_rd <= (state_nxt == S_FETCH) || (state_nxt == S_OPREAD);
         mem_wr <= (state_nxt == S_STORE);

         if (state_nxt == S_FETCH)
            mem_addr <= pc_nxt;
         else if (state_nxt == S_OPREAD || state_nxt == S_STORE)
            mem_addr <= tgt;

         if (state_nxt == S_STORE) mem_wdata <= acc;

         if (restart)      bus_err <= 1'b0;
         else if (timeout) bus_err <= 1'b1;

         if (state == S_FETCH && mem_ready)  ir  <= mem_rdata;
         if (state == S_OPREAD && mem_ready) mdr <= mem_rdata;
         if (state == S_DECODE)              alu_opcode <= op;

         if (state == S_EXEC) begin
            if (op == OP_LDA) begin
               acc    <= mdr;
               z_flag <= (mdr == 8'h00);
            end else begin
               acc    <= alu_result;
               z_flag <= (alu_result == 8'h00);
               c_flag <= (op == OP_ADD) && alu_carry;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed ISA programs plus random programs against an instruction-level model.
module tb_alu_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [4:0] mem_addr, pc;
   logic       mem_rd, mem_wr, mem_ready;
   logic [7:0] mem_wdata, mem_rdata;
   logic [2:0] alu_opcode;
   logic [7:0] alu_a, alu_b, alu_result, acc;
   logic       alu_carry, z_flag, c_flag, halted, bus_err;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.ADDR_W(5), .RESET_PC(0), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_carry(alu_carry),
      .acc(acc), .pc(pc), .z_flag(z_flag), .c_flag(c_flag),
      .halted(halted), .bus_err(bus_err)
   );

   // Combinational ALU; carry is garbage (1) for everything except add.
   logic [8:0] alu_sum;
   always_comb begin
      alu_sum = 9'h1AA;
      case (alu_opcode)
         3'b000: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
         3'b001: alu_sum = {1'b1, alu_a - alu_b};
         3'b100: alu_sum = {1'b1, alu_a & alu_b};
         3'b101: alu_sum = {1'b1, alu_a ^ alu_b};
         default: ;
      endcase
   end
   assign alu_result = alu_sum[7:0];
   assign alu_carry  = alu_sum[8];

   int         checks = 0, failures = 0;
   logic [7:0] mem [32];
   logic [7:0] rm  [32];
   logic [7:0] m_acc = 8'h00;
   logic       m_z = 1'b0, m_c = 1'b0;
   logic [4:0] m_pc = 5'd0;
   int         max_wait = 0, wr_force = -1, wr_cycles = 0, wait_left = 0;
   bit         no_ready = 0, in_xfer = 0, x_wr = 0;
   logic [4:0] x_addr;
   logic [7:0] x_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory responder, evaluated just after each clock edge for the next one.
   task automatic drive_mem();
      mem_rdata = 8'($urandom);
      if (!mem_rd && !mem_wr) begin
         in_xfer   = 0;
         mem_ready = 1'($urandom_range(1));
         return;
      end
      mem_ready = 1'b0;
      chk("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
      if (!in_xfer) begin
         in_xfer   = 1;
         x_addr    = mem_addr;
         x_wdata   = mem_wdata;
         x_wr      = mem_wr;
         wait_left = (mem_wr && wr_force >= 0) ? wr_force : int'($urandom_range(max_wait));
      end else begin
         chk("hs_addr", mem_addr, x_addr);
         chk("hs_wr", mem_wr, x_wr);
         if (x_wr) chk("hs_wdata", mem_wdata, x_wdata);
      end
      if (mem_wr) wr_cycles++;
      if (!no_ready) begin
         if (wait_left == 0) begin
            mem_ready = 1'b1;
            in_xfer   = 0;
            if (mem_rd) mem_rdata = mem[mem_addr];
            else        mem[mem_addr] = mem_wdata;
         end else begin
            wait_left--;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drive_mem();
   endtask

   task automatic launch();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_halt(output int n);
      n = 0;
      while (!halted && n < 3000) begin
         tick();
         n++;
      end
      chk("halt_reached", {31'd0, halted}, 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_rd"}, mem_rd, 0);
      chk({tag, "_wr"}, mem_wr, 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
      chk({tag, "_aluop"}, alu_opcode, 0);
      chk({tag, "_acc"}, acc, 0);
      chk({tag, "_mdr"}, alu_b, 0);
      chk({tag, "_pc"}, pc, 0);
      chk({tag, "_zc"}, {z_flag, c_flag}, 0);
      chk({tag, "_halted"}, halted, 0);
      chk({tag, "_buserr"}, bus_err, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n   = 1'b1;
      in_xfer = 0;
      m_acc = 8'h00; m_z = 1'b0; m_c = 1'b0;
   endtask

   // Instruction-level reference: runs rm[] from address 0 until HLT, returns zero-wait cycles.
   task automatic model_run(output int cyc);
      logic [4:0] p, a;
      logic [7:0] ins, opnd;
      logic [8:0] s;
      bit         done;
      p = 5'd0; cyc = 0; done = 0;
      for (int k = 0; k < 64 && !done; k++) begin
         ins = rm[p]; a = ins[4:0]; opnd = rm[a]; p = p + 5'd1;
         case (ins[7:5])
            3'd0: begin s = {1'b0, m_acc} + {1'b0, opnd}; m_acc = s[7:0]; m_c = s[8]; end
            3'd1: begin m_acc = m_acc - opnd; m_c = 1'b0; end
            3'd2: m_acc = opnd;
            3'd4: begin m_acc = m_acc & opnd; m_c = 1'b0; end
            3'd5: begin m_acc = m_acc ^ opnd; m_c = 1'b0; end
            3'd3: rm[a] = m_acc;
            3'd6: p = a;
            default: begin
               if (a == 5'd0) done = 1;
               else if (a == 5'd1 && m_z) p = p + 5'd1;
            end
         endcase
         case (ins[7:5])
            3'd0, 3'd1, 3'd2, 3'd4, 3'd5: begin m_z = (m_acc == 8'h00); cyc += 4; end
            3'd3:    cyc += 3;
            default: cyc += 2;
         endcase
      end
      m_pc = p;
   endtask

   task automatic prep_model();
      for (int i = 0; i < 32; i++) rm[i] = mem[i];
   endtask

   task automatic check_model(input string tag);
      int bad = 0;
      for (int i = 0; i < 32; i++) if (mem[i] !== rm[i]) bad++;
      chk({tag, "_acc"}, acc, m_acc);
      chk({tag, "_z"}, z_flag, m_z);
      chk({tag, "_c"}, c_flag, m_c);
      chk({tag, "_pc"}, pc, m_pc);
      chk({tag, "_buserr"}, bus_err, 0);
      chk({tag, "_memdiff"}, bad, 0);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
   endtask

   task automatic gen_prog();
      logic [2:0] op;
      logic [4:0] a;
      for (int i = 0; i < 14; i++) begin
         op = 3'($urandom_range(7));
         case (op)
            3'd6:    a = 5'($urandom_range(15, i + 1));
            3'd7:    a = 5'($urandom_range(3));
            default: a = 5'(16 + $urandom_range(15));
         endcase
         mem[i] = {op, a};
      end
      mem[14] = 8'hE0;
      mem[15] = 8'hE0;
      for (int i = 16; i < 32; i++) mem[i] = 8'($urandom);
   endtask

   initial begin
      int n, mc;
      mem_ready = 1'b0;
      mem_rdata = 8'h00;
      clear_mem();
      #2;
      rst_n = 1'b0;
      repeat (2) tick();
      check_reset_vals("rst");
      rst_n = 1'b1;
      tick();
      check_reset_vals("idle");

      // M[0] decodes as ADD 26; from acc=0 it behaves like LDA 26.
      mem[0] = 8'h1A; mem[1] = 8'h1B; mem[2] = 8'hE0; mem[26] = 8'hF0; mem[27] = 8'h20;
      prep_model(); model_run(mc);
      launch(); wait_halt(n);
      chk("p1_cycles", n, 10);
      chk("p1_acc", acc, 8'h10);
      chk("p1_cz", {c_flag, z_flag}, 2'b10);
      chk("p1_pc", pc, 3);
      check_model("p1");

      no_ready = 1;
      launch(); wait_halt(n);
      chk("to_cycles", n, 15);
      chk("to_buserr", bus_err, 1);
      chk("to_rd", mem_rd, 0);
      chk("to_acc", acc, 8'h10);
      chk("to_pc", pc, 0);
      no_ready = 0;

      clear_mem();
      mem[0] = 8'h54; mem[1] = 8'h35; mem[2] = 8'hE1; mem[3] = 8'hE0; mem[4] = 8'hE0;
      mem[20] = 8'h55; mem[21] = 8'h55;
      prep_model(); model_run(mc);
      launch();
      chk("rs_buserr", bus_err, 0);
      chk("rs_rd", mem_rd, 1);
      chk("rs_addr", mem_addr, 0);
      wait_halt(n);
      chk("sub_cycles", n, 12);
      chk("sub_acc", acc, 0);
      chk("sub_zc", {z_flag, c_flag}, 2'b10);
      chk("skz_pc", pc, 5);
      check_model("sub");

      clear_mem();
      mem[0] = 8'h54; mem[1] = 8'h76; mem[2] = 8'hE0; mem[20] = 8'hA5;
      prep_model(); model_run(mc);
      wr_force = 3; wr_cycles = 0;
      launch(); wait_halt(n);
      wr_force = -1;
      chk("sta_wr_cycles", wr_cycles, 4);
      chk("sta_mem", mem[22], 8'hA5);
      check_model("sta");

      clear_mem();
      for (int i = 0; i < 4; i++) mem[i] = 8'h14;
      mem[4] = 8'hE0; mem[20] = 8'h11;
      prep_model(); model_run(mc);
      launch();
      repeat (4) tick();
      start = 1'b1; tick(); start = 1'b0;
      wait_halt(n);
      chk("ign_cycles", n + 5, mc);
      check_model("ign");

      clear_mem();
      mem[0] = 8'hDF; mem[31] = 8'hE2;
      launch(); tick(); tick();
      chk("jmp_pc", pc, 31);
      chk("jmp_addr", mem_addr, 31);
      tick(); tick();
      chk("wrap_pc", pc, 0);
      chk("wrap_addr", mem_addr, 0);
      do_reset();

      clear_mem();
      mem[0] = 8'h54; mem[1] = 8'h55; mem[2] = 8'hE0; mem[20] = 8'h77; mem[21] = 8'h33;
      launch();
      repeat (6) tick();
      chk("opr_rd", mem_rd, 1);
      chk("opr_addr", mem_addr, 21);
      chk("opr_acc", acc, 8'h77);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      repeat (2) tick();
      rst_n = 1'b1;
      in_xfer = 0;
      m_acc = 8'h00; m_z = 1'b0; m_c = 1'b0;

      for (int k = 0; k < 24; k++) begin
         max_wait = (k < 6) ? 0 : 3;
         gen_prog();
         prep_model(); model_run(mc);
         launch(); wait_halt(n);
         if (max_wait == 0) chk("rnd_cycles", n, mc);
         check_model("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
